rc4_phase_sequencer: RTL
========================

// Module: rc4_phase_sequencer
// PURPOSE
//  Top-level phase controller for the RC4 decryption core. Sequences the three
//  S-memory engines (S init, KSA swap, PRGA decrypt) through start/finished
//  handshakes. Owns the single-port S RAM and muxes exactly one engine's
//  address/data/wren onto it per phase. Sits between the top-level start/done
//  and ram_initializer, ksa_engine and prga_engine.
// PARAMETERS
//  ADDR_W         8     S RAM address width
//  DATA_W         8     S RAM data width
//  TIMEOUT_CYCLES 2048  per-phase watchdog limit (only with PHASE_TIMEOUT_EN)
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       synchronous, active-high
//  start         in   1       top-level run request (level)
//  done          out  1       all three phases complete
//  busy          out  1       high in INIT/KSA/PRGA
//  phase         out  3       state code: IDLE=0 INIT=1 KSA=2 PRGA=3 DONE=4 ERR=5
//  error         out  1       watchdog fired (0 when PHASE_TIMEOUT_EN undefined)
//  init_start    out  1       to ram_initializer
//  init_finished in   1
//  init_address  in   ADDR_W
//  init_data     in   DATA_W
//  init_wren     in   1
//  ksa_start / ksa_finished / ksa_address / ksa_data / ksa_wren    same, KSA engine
//  prga_start / prga_finished / prga_address / prga_data / prga_wren same, PRGA engine
//  ram_address   out  ADDR_W  to S RAM
//  ram_data      out  DATA_W  to S RAM
//  ram_wren      out  1       to S RAM (RAM read data is wired to all engines directly)
// BEHAVIOUR
//  - Reset: state=IDLE; done, busy, error, all *_start, ram_wren = 0; ram_address
//    and ram_data = 0. Reset mid-phase aborts immediately; RAM contents undefined.
//  - IDLE:  start=1 -> INIT next cycle.
//  - INIT:  init_start=1. init_finished=1 -> KSA next cycle.
//  - KSA:   ksa_start=1. ksa_finished=1 -> PRGA next cycle.
//  - PRGA:  prga_start=1. prga_finished=1 -> DONE next cycle.
//  - DONE:  done=1. Stay while start=1; start=0 -> IDLE (re-arm). Each assertion
//    of start yields exactly one full run.
//  - *_start, done, busy and phase are decoded from the state register only.
//    An engine's start is high for every cycle of its phase and drops the cycle
//    after its finished is sampled. The next engine's start rises that same
//    cycle, so there is zero idle cycle between phases.
//  - finished from a non-active engine is ignored in every state.
//  - start dropping during INIT/KSA/PRGA does not abort the run; the sequence
//    completes to DONE and then returns to IDLE the next cycle.
//  - RAM mux is combinational from state, with no added latency:
//    INIT->init_*, KSA->ksa_*, PRGA->prga_*.
//    IDLE/DONE/ERR -> ram_address=0, ram_data=0, ram_wren=0.
//  - Engine finished is treated as a level and sampled once on entry to the
//    transition; holding it high after the phase changes has no effect.
// CONFIGURATION
//  PHASE_TIMEOUT_EN defined:
//   - A counter of ceil(log2(TIMEOUT_CYCLES+1)) bits clears on every phase entry
//     and increments each cycle in INIT/KSA/PRGA.
//   - When count == TIMEOUT_CYCLES and the active finished is 0 -> ERR next cycle.
//     If finished=1 on that same cycle, finished wins.
//   - ERR: error=1, all *_start=0, ram_wren=0. Exits only via reset, or via
//     start=0 -> IDLE (error clears on exit).
//  PHASE_TIMEOUT_EN undefined: no counter; ERR unreachable; error tied to 0.
// TESTING
//  1. Reset then start=1; engine models finish after 256/768/300 cycles ->
//     phase 1->2->3->4; done=1 one cycle after prga_finished; start overlap 0 cycles.
//  2. During each phase, drive distinct address/data/wren on all three engines ->
//     ram_* equals only the active engine's values; in IDLE/DONE ram_wren=0.
//  3. Pulse ksa_finished during INIT and prga_finished during KSA ->
//     ignored; phase unchanged.
//  4. start=0 at cycle 50 of KSA -> run completes; DONE held 1 cycle, then IDLE.
//     Raise start again -> second full run.
//  5. reset=1 mid-KSA -> next cycle phase=0, all *_start=0, ram_wren=0, done=0.
//  6. PHASE_TIMEOUT_EN, TIMEOUT_CYCLES=16, KSA engine never finishes ->
//     ERR after 17 KSA cycles, error=1. Drop start -> IDLE, error=0.
//     Repeat with finished on cycle 16 -> PRGA, no ERR.

Source files
------------

// File: rtl/rc4_phase_sequencer.sv
// RC4 core phase controller: sequences S-init, KSA and PRGA engines and muxes
// the active engine onto the shared S RAM. Optional watchdog: `define PHASE_TIMEOUT_EN.
module rc4_phase_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [2:0]        phase,
    output logic              error,
    output logic              init_start,
    input  logic              init_finished,
    input  logic [ADDR_W-1:0] init_address,
    input  logic [DATA_W-1:0] init_data,
    input  logic              init_wren,
    output logic              ksa_start,
    input  logic              ksa_finished,
    input  logic [ADDR_W-1:0] ksa_address,
    input  logic [DATA_W-1:0] ksa_data,
    input  logic              ksa_wren,
    output logic              prga_start,
    input  logic              prga_finished,
    input  logic [ADDR_W-1:0] prga_address,
    input  logic [DATA_W-1:0] prga_data,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_KSA  = 3'd2,
        S_PRGA = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t state, state_next;
    logic   timeout;

`ifdef PHASE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Cleared on every state change so each phase gets its own budget.
    always_ff @(posedge clk) begin
        if (reset)                    cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else if (busy)                cnt <= cnt + 1'b1;
    end

    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES));
    assign error   = (state == S_ERR);
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // A finished on the timeout cycle wins over the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_INIT;
            S_INIT: if (init_finished) state_next = S_KSA;
                    else if (timeout)  state_next = S_ERR;
            S_KSA:  if (ksa_finished)  state_next = S_PRGA;
                    else if (timeout)  state_next = S_ERR;
            S_PRGA: if (prga_finished) state_next = S_DONE;
                    else if (timeout)  state_next = S_ERR;
            S_DONE: if (!start) state_next = S_IDLE;
            S_ERR:  if (!start) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign phase = state;

    always_comb begin
        done        = 1'b0;
        busy        = 1'b0;
        init_start  = 1'b0;
        ksa_start   = 1'b0;
        prga_start  = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        case (state)
            S_INIT: begin
                busy        = 1'b1;
                init_start  = 1'b1;
                ram_address = init_address;
                ram_data    = init_data;
                ram_wren    = init_wren;
            end
            S_KSA: begin
                busy        = 1'b1;
                ksa_start   = 1'b1;
                ram_address = ksa_address;
                ram_data    = ksa_data;
                ram_wren    = ksa_wren;
            end
            S_PRGA: begin
                busy        = 1'b1;
                prga_start  = 1'b1;
                ram_address = prga_address;
                ram_data    = prga_data;
                ram_wren    = prga_wren;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
